// File: rtl/if_id_stage_reg_pkg.sv
// Shared IF/ID definitions: instruction field positions, the bubble word and the
// opcodes the control unit decodes.
package if_id_stage_reg_pkg;

   localparam int          DATA_W   = 32;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;  // sll $0,$0,0

   localparam int OPCODE_HI = 31, OPCODE_LO = 26;
   localparam int RS_HI     = 25, RS_LO     = 21;
   localparam int RT_HI     = 20, RT_LO     = 16;
   localparam int RD_HI     = 15, RD_LO     = 11;
   localparam int SHAMT_HI  = 10, SHAMT_LO  = 6;
   localparam int FUNCT_HI  = 5,  FUNCT_LO  = 0;
   localparam int IMM_HI    = 15, IMM_LO    = 0;
   localparam int JT_HI     = 25, JT_LO     = 0;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/if_id_stage_reg_instr_field_split.sv
// Combinational split of a 32-bit instruction into its decode fields; shared with
// the control and hazard units.
module instr_field_split
   import if_id_stage_reg_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic [5:0]  o_opcode,
   output logic [4:0]  o_rs,
   output logic [4:0]  o_rt,
   output logic [4:0]  o_rd,
   output logic [4:0]  o_shamt,
   output logic [5:0]  o_funct,
   output logic [15:0] o_imm16,
   output logic [25:0] o_jump_target
);

   assign o_opcode      = i_instr[OPCODE_HI:OPCODE_LO];
   assign o_rs          = i_instr[RS_HI:RS_LO];
   assign o_rt          = i_instr[RT_HI:RT_LO];
   assign o_rd          = i_instr[RD_HI:RD_LO];
   assign o_shamt       = i_instr[SHAMT_HI:SHAMT_LO];
   assign o_funct       = i_instr[FUNCT_HI:FUNCT_LO];
   assign o_imm16       = i_instr[IMM_HI:IMM_LO];
   assign o_jump_target = i_instr[JT_HI:JT_LO];

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with stall/flush and decode field split.
// Optional performance counters enabled by defining IF_ID_PERF_CNT_EN.
module if_id_stage_reg
   import if_id_stage_reg_pkg::*;
#(
   parameter int          DATA_W   = if_id_stage_reg_pkg::DATA_W,
   parameter logic [31:0] NOP_WORD = if_id_stage_reg_pkg::NOP_WORD
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [DATA_W-1:0] IF_Instruction,
   input  logic [DATA_W-1:0] IF_PCPlus4,
   input  logic              IF_Valid,
   input  logic              Stall,
   input  logic              Flush,
   output logic [DATA_W-1:0] ID_Instruction,
   output logic [DATA_W-1:0] ID_PCPlus4,
   output logic              ID_Valid,
   output logic [5:0]        ID_Opcode,
   output logic [4:0]        ID_Rs,
   output logic [4:0]        ID_Rt,
   output logic [4:0]        ID_Rd,
   output logic [4:0]        ID_Shamt,
   output logic [5:0]        ID_Funct,
   output logic [15:0]       ID_Imm16,
`ifdef IF_ID_PERF_CNT_EN
   output logic [25:0]       ID_JumpTarget,
   output logic [31:0]       StallCycles,
   output logic [31:0]       FlushCycles,
   output logic [31:0]       BubbleCycles
`else
   output logic [25:0]       ID_JumpTarget
`endif
);

   logic [DATA_W-1:0] r_instr;
   logic [DATA_W-1:0] r_pc4;
   logic              r_valid;
   logic              w_take;

   // A flushed or invalid slot always becomes the bubble word, so Valid=0 never
   // exposes stale fetch data to decode.
   assign w_take = IF_Valid & ~Flush;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_instr <= NOP_WORD[DATA_W-1:0];
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (!Stall) begin
         r_pc4   <= IF_PCPlus4;
         r_valid <= w_take;
         r_instr <= w_take ? IF_Instruction : NOP_WORD[DATA_W-1:0];
      end
   end

   assign ID_Instruction = r_instr;
   assign ID_PCPlus4     = r_pc4;
   assign ID_Valid       = r_valid;

   instr_field_split u_split (
      .i_instr       (r_instr[31:0]),
      .o_opcode      (ID_Opcode),
      .o_rs          (ID_Rs),
      .o_rt          (ID_Rt),
      .o_rd          (ID_Rd),
      .o_shamt       (ID_Shamt),
      .o_funct       (ID_Funct),
      .o_imm16       (ID_Imm16),
      .o_jump_target (ID_JumpTarget)
   );

`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;
   logic [31:0] r_bubble_cnt;
   logic        w_new_valid;

   // Under stall the held Valid is the "new" one.
   assign w_new_valid = Stall ? r_valid : w_take;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_stall_cnt  <= '0;
         r_flush_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (Stall)          r_stall_cnt  <= sat_inc(r_stall_cnt);
         if (Flush & ~Stall) r_flush_cnt  <= sat_inc(r_flush_cnt);
         if (!w_new_valid)   r_bubble_cnt <= sat_inc(r_bubble_cnt);
      end
   end

   assign StallCycles  = r_stall_cnt;
   assign FlushCycles  = r_flush_cnt;
   assign BubbleCycles = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed bench for if_id_stage_reg: a transaction-level model of the stage,
// checked every falling edge, plus hand-computed literal expectations.
module tb_if_id_stage_reg;

   logic        Clk, Reset_n;
   logic [31:0] IF_Instruction, IF_PCPlus4;
   logic        IF_Valid, Stall, Flush;
   logic [31:0] ID_Instruction, ID_PCPlus4;
   logic        ID_Valid;
   logic [5:0]  ID_Opcode, ID_Funct;
   logic [4:0]  ID_Rs, ID_Rt, ID_Rd, ID_Shamt;
   logic [15:0] ID_Imm16;
   logic [25:0] ID_JumpTarget;
`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] StallCycles, FlushCycles, BubbleCycles;
   logic [31:0] m_stc, m_flc, m_bbc;
`endif

   int total = 0;
   int bad   = 0;
   bit started = 0;

   // Model of what decode must see: the last accepted slot.
   logic [31:0] m_instr, m_pc;
   logic        m_valid;

   if_id_stage_reg dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .IF_Instruction(IF_Instruction), .IF_PCPlus4(IF_PCPlus4), .IF_Valid(IF_Valid),
      .Stall(Stall), .Flush(Flush),
      .ID_Instruction(ID_Instruction), .ID_PCPlus4(ID_PCPlus4), .ID_Valid(ID_Valid),
      .ID_Opcode(ID_Opcode), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
      .ID_Shamt(ID_Shamt), .ID_Funct(ID_Funct), .ID_Imm16(ID_Imm16),
`ifdef IF_ID_PERF_CNT_EN
      .ID_JumpTarget(ID_JumpTarget),
      .StallCycles(StallCycles), .FlushCycles(FlushCycles), .BubbleCycles(BubbleCycles)
`else
      .ID_JumpTarget(ID_JumpTarget)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0;
`ifdef IF_ID_PERF_CNT_EN
      m_stc = 0; m_flc = 0; m_bbc = 0;
`endif
   endtask

   // Present one fetch slot, take one rising edge, advance the model.
   task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                       input logic st, input logic fl);
      IF_Instruction = ins; IF_PCPlus4 = pc; IF_Valid = v; Stall = st; Flush = fl;
      @(posedge Clk);
      if (!st) begin
         m_pc = pc;
         if (fl || !v) begin m_instr = 32'h0; m_valid = 1'b0; end
         else          begin m_instr = ins;   m_valid = 1'b1; end
      end
`ifdef IF_ID_PERF_CNT_EN
      if (st && m_stc != 32'hFFFF_FFFF) m_stc++;
      if (fl && !st && m_flc != 32'hFFFF_FFFF) m_flc++;
      if (!m_valid && m_bbc != 32'hFFFF_FFFF) m_bbc++;
`endif
      #1;
   endtask

   always @(negedge Clk) begin
      if (started) begin
         chk("instr",  ID_Instruction, m_instr);
         chk("pc4",    ID_PCPlus4,     m_pc);
         chk("valid",  {31'b0, ID_Valid}, {31'b0, m_valid});
         chk("opcode", {26'b0, ID_Opcode}, m_instr / 32'h0400_0000);
         chk("rs",     {27'b0, ID_Rs},     (m_instr / 32'h20_0000) % 32);
         chk("rt",     {27'b0, ID_Rt},     (m_instr / 32'h1_0000) % 32);
         chk("rd",     {27'b0, ID_Rd},     (m_instr / 32'h800) % 32);
         chk("shamt",  {27'b0, ID_Shamt},  (m_instr / 64) % 32);
         chk("funct",  {26'b0, ID_Funct},  m_instr % 64);
         chk("imm16",  {16'b0, ID_Imm16},  m_instr % 32'h1_0000);
         chk("jtgt",   {6'b0, ID_JumpTarget}, m_instr % 32'h0400_0000);
         if (!m_valid) chk("bubble_inv", ID_Instruction, 32'h0);
`ifdef IF_ID_PERF_CNT_EN
         chk("stall_cnt",  StallCycles,  m_stc);
         chk("flush_cnt",  FlushCycles,  m_flc);
         chk("bubble_cnt", BubbleCycles, m_bbc);
`endif
      end
   end

   initial begin
      Reset_n = 1'b0;
      IF_Instruction = 32'h0; IF_PCPlus4 = 32'h0; IF_Valid = 1'b0; Stall = 1'b0; Flush = 1'b0;
      model_reset();
      started = 1;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;

      // 1: load, async reset mid-cycle, then sll $4,$2,5
      step(32'h8C22_0004, 32'h10, 1, 0, 0);
      chk("pre_rst_instr", ID_Instruction, 32'h8C22_0004);
      #2 Reset_n = 1'b0;
      #1;
      model_reset();
      chk("rst_instr", ID_Instruction, 32'h0);
      chk("rst_pc4",   ID_PCPlus4,     32'h0);
      chk("rst_valid", {31'b0, ID_Valid}, 32'h0);
      chk("rst_rs",    {27'b0, ID_Rs},    32'h0);
      @(negedge Clk);
      Reset_n = 1'b1;
      step(32'h0002_2140, 32'h14, 1, 0, 0);
      chk("t1_shamt", {27'b0, ID_Shamt}, 32'd5);
      chk("t1_rt",    {27'b0, ID_Rt},    32'd2);
      chk("t1_rd",    {27'b0, ID_Rd},    32'd4);
      chk("t1_funct", {26'b0, ID_Funct}, 32'd0);
      chk("t1_pc4",   ID_PCPlus4,        32'h14);
      chk("t1_valid", {31'b0, ID_Valid}, 32'd1);

      // 2: stall hold for 3 edges
      for (int i = 0; i < 3; i++) begin
         step(32'h8C22_0004, 32'h18, 1, 1, 0);
         chk("t2_hold", ID_Instruction, 32'h0002_2140);
      end
      step(32'h8C22_0004, 32'h18, 1, 0, 0);
      chk("t2_release", ID_Instruction, 32'h8C22_0004);
      chk("t2_rs", {27'b0, ID_Rs}, 32'd1);

      // 3: flush
      step(32'h1022_FFFC, 32'h1C, 1, 0, 1);
      chk("t3_instr", ID_Instruction, 32'h0);
      chk("t3_valid", {31'b0, ID_Valid}, 32'd0);
      chk("t3_imm16", {16'b0, ID_Imm16}, 32'd0);
      chk("t3_pc4",   ID_PCPlus4, 32'h1C);

      // 4: stall+flush holds, then flush alone bubbles
      step(32'h1022_FFFC, 32'h1C, 1, 0, 0);
      chk("t4_load_imm", {16'b0, ID_Imm16}, 32'h0000_FFFC);
      step(32'h2001_0007, 32'h20, 1, 1, 1);
      chk("t4_hold",  ID_Instruction, 32'h1022_FFFC);
      chk("t4_hold_v", {31'b0, ID_Valid}, 32'd1);
      step(32'h2001_0007, 32'h20, 1, 0, 1);
      chk("t4_bubble", ID_Instruction, 32'h0);
      chk("t4_pc4",    ID_PCPlus4, 32'h20);

      // 5: invalid fetch never exposed
      step(32'hFFFF_FFFF, 32'h24, 0, 0, 0);
      chk("t5_instr", ID_Instruction, 32'h0);
      chk("t5_shamt", {27'b0, ID_Shamt}, 32'd0);
      chk("t5_pc4",   ID_PCPlus4, 32'h24);

      // Jump load, then unknown fetch data under a long stall
      step(32'h0AB1_2345, 32'h28, 1, 0, 0);
      chk("j_opcode", {26'b0, ID_Opcode}, 32'h2);
      chk("j_target", {6'b0, ID_JumpTarget}, 32'h02B1_2345);
      for (int i = 0; i < 10; i++) step(32'hx, 32'hx, 1'bx, 1, 0);
      chk("x_hold", ID_Instruction, 32'h0AB1_2345);
      chk("x_pc4",  ID_PCPlus4, 32'h28);

      // Stall released with flush in the same cycle
      step(32'h8C22_0004, 32'h2C, 1, 0, 1);
      chk("rel_flush", ID_Instruction, 32'h0);
      step(32'hAC43_0008, 32'h30, 1, 0, 0);
      chk("sw_rt", {27'b0, ID_Rt}, 32'd3);
      step(32'h0000_0000, 32'h34, 1, 0, 0);

`ifdef IF_ID_PERF_CNT_EN
      chk("perf_stall_lit", StallCycles, 32'd14);
      chk("perf_flush_lit", FlushCycles, 32'd3);
`endif

      @(negedge Clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
